// File: rtl/rv32_mod_writeback.sv
// Writeback arbiter for an RV32 core: merges ALU and load-unit results onto one
// register-file write port and tracks registers awaiting load data.
module rv32_mod_writeback #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_index,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_index,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_index,
    input  logic [4:0]  query0_index,
    input  logic [4:0]  query1_index,
    output logic        query0_busy,
    output logic        query1_busy,
    output logic [31:0] pending_mask,
    output logic [4:0]  write0_index,
    output logic [31:0] write0_data,
    output logic        write0_enable
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e      last_grant_q, last_grant_d;
    logic [31:0] pending_q, pending_d;
    logic [4:0]  wr_index_q, wr_index_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic        conflict_s;
    logic        grant_alu_s, grant_mem_s;
    logic [31:0] set_mask_s, clear_mask_s;

    // A register counts as busy while pending or while its value is still in the write stage.
    function automatic logic query_busy(input logic [4:0]  idx,
                                        input logic [31:0] pend,
                                        input logic        wen,
                                        input logic [4:0]  widx);
        logic busy;
        if (idx == 5'd0) begin
            busy = 1'b0;
        end else begin
            busy = pend[idx] | (wen & (widx == idx));
        end
        return busy;
    endfunction

    // Arbitration: single requester wins; on conflict MEM wins unless round-robin says ALU.
    always_comb begin
        conflict_s  = alu_valid & mem_valid;
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        if (reset) begin
            grant_alu_s = 1'b0;
            grant_mem_s = 1'b0;
        end else if (conflict_s) begin
            if (ROUND_ROBIN && (last_grant_q == GRANT_MEM)) begin
                grant_alu_s = 1'b1;
            end else begin
                grant_mem_s = 1'b1;
            end
        end else begin
            grant_alu_s = alu_valid;
            grant_mem_s = mem_valid;
        end
    end

    // Next-state for grant history, scoreboard and the write stage.
    always_comb begin
        last_grant_d = last_grant_q;
        wr_index_d   = wr_index_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        if (conflict_s && !reset) begin
            last_grant_d = grant_mem_s ? GRANT_MEM : GRANT_ALU;
        end else begin
            last_grant_d = last_grant_q;
        end

        set_mask_s   = (issue_valid && (issue_index != 5'd0)) ? (32'h1 << issue_index) : 32'h0;
        clear_mask_s = grant_mem_s ? (32'h1 << mem_index) : 32'h0;
        // Set is applied after clear so a same-cycle reissue keeps the register pending.
        pending_d    = ((pending_q & ~clear_mask_s) | set_mask_s) & 32'hFFFF_FFFE;

        if (grant_alu_s) begin
            wr_index_d = alu_index;
            wr_data_d  = alu_data;
            wr_en_d    = (alu_index != 5'd0);
        end else if (grant_mem_s) begin
            wr_index_d = mem_index;
            wr_data_d  = mem_data;
            wr_en_d    = (mem_index != 5'd0);
        end else begin
            wr_en_d    = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_ALU;
            pending_q    <= 32'h0;
            wr_index_q   <= 5'd0;
            wr_data_q    <= 32'h0;
            wr_en_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            wr_index_q   <= wr_index_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
        end
    end

    assign alu_ready     = grant_alu_s;
    assign mem_ready     = grant_mem_s;
    assign pending_mask  = pending_q;
    assign write0_index  = wr_index_q;
    assign write0_data   = wr_data_q;
    assign write0_enable = wr_en_q;
    assign query0_busy   = query_busy(query0_index, pending_q, wr_en_q, wr_index_q);
    assign query1_busy   = query_busy(query1_index, pending_q, wr_en_q, wr_index_q);

endmodule

// File: tb/tb_rv32_mod_writeback.sv
// Directed bench for rv32_mod_writeback: round-robin and fixed-priority instances
// share stimulus; expected values are hand-computed constants.
module tb_rv32_mod_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_index, mem_index, issue_index, query0_index, query1_index;
    logic [31:0] alu_data, mem_data;

    logic        r_alu_ready, r_mem_ready, r_q0_busy, r_q1_busy, r_wen;
    logic [31:0] r_pending, r_wdata;
    logic [4:0]  r_windex;
    logic        f_alu_ready, f_mem_ready, f_q0_busy, f_q1_busy, f_wen;
    logic [31:0] f_pending, f_wdata;
    logic [4:0]  f_windex;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv32_mod_writeback #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_index(alu_index), .alu_data(alu_data), .alu_ready(r_alu_ready),
        .mem_valid(mem_valid), .mem_index(mem_index), .mem_data(mem_data), .mem_ready(r_mem_ready),
        .issue_valid(issue_valid), .issue_index(issue_index),
        .query0_index(query0_index), .query1_index(query1_index),
        .query0_busy(r_q0_busy), .query1_busy(r_q1_busy), .pending_mask(r_pending),
        .write0_index(r_windex), .write0_data(r_wdata), .write0_enable(r_wen)
    );

    rv32_mod_writeback #(.ROUND_ROBIN(1'b0)) dut_fx (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_index(alu_index), .alu_data(alu_data), .alu_ready(f_alu_ready),
        .mem_valid(mem_valid), .mem_index(mem_index), .mem_data(mem_data), .mem_ready(f_mem_ready),
        .issue_valid(issue_valid), .issue_index(issue_index),
        .query0_index(query0_index), .query1_index(query1_index),
        .query0_busy(f_q0_busy), .query1_busy(f_q1_busy), .pending_mask(f_pending),
        .write0_index(f_windex), .write0_data(f_wdata), .write0_enable(f_wen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rr_pat;
        rr_pat       = 4'b0101;
        reset        = 1'b1;
        alu_valid    = 1'b1; alu_index = 5'd3; alu_data = 32'h1;
        mem_valid    = 1'b1; mem_index = 5'd4; mem_data = 32'h2;
        issue_valid  = 1'b1; issue_index = 5'd6;
        query0_index = 5'd0; query1_index = 5'd0;

        // reset: no grants, registers cleared
        #1;
        chk("rst alu_ready", {31'd0, r_alu_ready}, 32'd0);
        chk("rst mem_ready", {31'd0, r_mem_ready}, 32'd0);
        tick();
        tick();
        chk("rst pending", r_pending, 32'h0);
        chk("rst wen", {31'd0, r_wen}, 32'd0);
        chk("rst windex", {27'd0, r_windex}, 32'd0);
        chk("rst wdata", r_wdata, 32'h0);
        reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
        tick();
        chk("post-rst wen", {31'd0, r_wen}, 32'd0);

        // single ALU write
        alu_valid = 1'b1; alu_index = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        chk("alu1 alu_ready", {31'd0, r_alu_ready}, 32'd1);
        chk("alu1 mem_ready", {31'd0, r_mem_ready}, 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("alu1 wen", {31'd0, r_wen}, 32'd1);
        chk("alu1 windex", {27'd0, r_windex}, 32'd5);
        chk("alu1 wdata", r_wdata, 32'hDEADBEEF);
        chk("alu1 pending", r_pending, 32'h0);
        tick();
        chk("alu1 wen drop", {31'd0, r_wen}, 32'd0);

        // conflict stream
        alu_valid = 1'b1; alu_index = 5'd3; alu_data = 32'h1;
        mem_valid = 1'b1; mem_index = 5'd4; mem_data = 32'h2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr mem_ready", {31'd0, r_mem_ready}, {31'd0, rr_pat[i]});
            chk("rr alu_ready", {31'd0, r_alu_ready}, {31'd0, ~rr_pat[i]});
            chk("fx mem_ready", {31'd0, f_mem_ready}, 32'd1);
            chk("fx alu_ready", {31'd0, f_alu_ready}, 32'd0);
            tick();
            chk("rr windex", {27'd0, r_windex}, rr_pat[i] ? 32'd4 : 32'd3);
            chk("rr wdata", r_wdata, rr_pat[i] ? 32'd2 : 32'd1);
            chk("fx windex", {27'd0, f_windex}, 32'd4);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();

        // scoreboard set and clear
        issue_valid = 1'b1; issue_index = 5'd7;
        tick();
        issue_valid = 1'b0; query0_index = 5'd7;
        #1;
        chk("sb pending set", r_pending, 32'h00000080);
        chk("sb busy pending", {31'd0, r_q0_busy}, 32'd1);
        mem_valid = 1'b1; mem_index = 5'd7; mem_data = 32'h77;
        #1;
        chk("sb mem_ready", {31'd0, r_mem_ready}, 32'd1);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("sb pending clr", r_pending, 32'h0);
        chk("sb wen", {31'd0, r_wen}, 32'd1);
        chk("sb busy in write", {31'd0, r_q0_busy}, 32'd1);
        tick();
        chk("sb busy after", {31'd0, r_q0_busy}, 32'd0);

        // simultaneous set and clear
        issue_valid = 1'b1; issue_index = 5'd9;
        tick();
        query1_index = 5'd9;
        mem_valid = 1'b1; mem_index = 5'd9; mem_data = 32'h99;
        #1;
        chk("sc pending", r_pending, 32'h00000200);
        chk("sc busy1", {31'd0, r_q1_busy}, 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("sc pending kept", r_pending, 32'h00000200);
        chk("sc windex", {27'd0, r_windex}, 32'd9);
        tick();
        mem_valid = 1'b0;
        chk("sc pending clr", r_pending, 32'h0);
        tick();

        // index 0
        issue_valid = 1'b1; issue_index = 5'd0;
        mem_valid = 1'b1; mem_index = 5'd0; mem_data = 32'h55;
        query0_index = 5'd0; query1_index = 5'd0;
        #1;
        chk("x0 mem_ready", {31'd0, r_mem_ready}, 32'd1);
        tick();
        issue_valid = 1'b0; mem_valid = 1'b0;
        #1;
        chk("x0 pending", r_pending, 32'h0);
        chk("x0 wen", {31'd0, r_wen}, 32'd0);
        chk("x0 busy0", {31'd0, r_q0_busy}, 32'd0);
        chk("x0 busy1", {31'd0, r_q1_busy}, 32'd0);

        // reset mid-operation
        for (int k = 8; k < 12; k++) begin
            issue_valid = 1'b1; issue_index = 5'(k);
            tick();
        end
        issue_valid = 1'b0; query0_index = 5'd11;
        #1;
        chk("mr pending", r_pending, 32'h00000F00);
        chk("mr busy", {31'd0, r_q0_busy}, 32'd1);
        alu_valid = 1'b1; alu_index = 5'd1; alu_data = 32'h5;
        mem_valid = 1'b1; mem_index = 5'd0; mem_data = 32'h6;
        #1;
        chk("mr pre conflict mem", {31'd0, r_mem_ready}, 32'd1);
        tick();
        mem_valid = 1'b0; alu_index = 5'd12; alu_data = 32'hC0FFEE12;
        #1;
        chk("mr alu_ready", {31'd0, r_alu_ready}, 32'd1);
        tick();
        chk("mr inflight wen", {31'd0, r_wen}, 32'd1);
        chk("mr inflight idx", {27'd0, r_windex}, 32'd12);
        reset = 1'b1;
        mem_valid = 1'b1; mem_index = 5'd8;
        issue_valid = 1'b1; issue_index = 5'd13;
        #1;
        chk("mr rst alu_ready", {31'd0, r_alu_ready}, 32'd0);
        chk("mr rst mem_ready", {31'd0, r_mem_ready}, 32'd0);
        tick();
        chk("mr rst pending", r_pending, 32'h0);
        chk("mr rst wen", {31'd0, r_wen}, 32'd0);
        chk("mr rst windex", {27'd0, r_windex}, 32'd0);
        chk("mr rst wdata", r_wdata, 32'h0);
        chk("mr rst busy", {31'd0, r_q0_busy}, 32'd0);
        reset = 1'b0; issue_valid = 1'b0;
        alu_index = 5'd1; mem_index = 5'd0;
        #1;
        chk("mr fresh mem", {31'd0, r_mem_ready}, 32'd1);
        chk("mr fresh alu", {31'd0, r_alu_ready}, 32'd0);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("mr no pulse", {31'd0, r_wen}, 32'd0);
        chk("mr pending 0", r_pending, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rv32_mod_writeback.md
RV32_MOD_WRITEBACK -- requirements
Module: rv32_mod_writeback

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1: 1 = alternate grant on conflict; 0 = fixed MEM priority.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port alu_valid / alu_index / alu_data  input  1/5/32  ALU writeback request.
REQ-005 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-006 SHALL have port mem_valid / mem_index / mem_data  input  1/5/32  load-unit writeback request.
REQ-007 SHALL have port mem_ready  output  1  MEM request accepted this cycle.
REQ-008 SHALL have port issue_valid / issue_index  input  1/5  load issued; marks destination pending.
REQ-009 SHALL have port query0_index / query1_index  input  5/5  source registers to check.
REQ-010 SHALL have port query0_busy / query1_busy  output  1/1  source not yet readable from the register file.
REQ-011 SHALL have port pending_mask  output  32  registered scoreboard, bit i = x<i> awaiting load data.
REQ-012 SHALL have port write0_index / write0_data / write0_enable  output  5/32/1  drives the register-file write port.

Function
REQ-013 SHALL grant at most one request per cycle; a request transfers when valid && ready.
REQ-014 SHALL drive alu_ready/mem_ready combinationally from the valids and the grant state only, with no dependence on data or index.
REQ-015 SHALL, when only one source is valid, grant that source.
REQ-016 SHALL, on conflict with ROUND_ROBIN=1, grant the source not granted at the last conflict; the first conflict after reset grants MEM.
REQ-017 SHALL, on conflict with ROUND_ROBIN=0, always grant MEM.
REQ-018 SHALL update the last-grant flag only on conflict cycles.
REQ-019 SHALL register the granted request: write0_* reflect it exactly 1 cycle after the transfer.
REQ-020 SHALL deassert write0_enable in any cycle following a cycle with no transfer.
REQ-021 SHALL accept requests with index 0 but keep write0_enable at 0 for them.
REQ-022 SHALL set pending_mask[issue_index] at the edge after issue_valid, if issue_index != 0.
REQ-023 SHALL clear pending_mask[mem_index] at the edge after a MEM transfer.
REQ-024 SHALL keep the bit set when the same index is both set and cleared in one cycle, because the set has priority.
REQ-025 SHALL NOT let ALU transfers alter pending_mask.
REQ-026 SHALL keep pending_mask[0] at 0 always.
REQ-027 SHALL compute queryN_busy = pending_mask[idx] OR (write0_enable AND write0_index == idx), and force it to 0 when idx == 0.
REQ-028 SHALL hold last-grant and pending state when neither source is valid.

Reset
REQ-029 SHALL, while reset is high at a clock edge, clear pending_mask to 0, write0_enable to 0, write0_index to 0, write0_data to 0, and the last-grant flag to "ALU".
REQ-030 SHALL drive alu_ready and mem_ready to 0 while reset is asserted, and accept no transfers.
REQ-031 SHALL discard requests and issues presented during the reset cycle, including ones that arrive mid-operation.
REQ-032 SHALL re-arbitrate from a fresh state in the first cycle after reset deasserts.

Verification
REQ-033 SHALL test a single ALU write: alu_valid, index 5, data 0xDEADBEEF -> alu_ready=1 that cycle; next cycle write0_enable=1, write0_index=5, write0_data=0xDEADBEEF; following cycle write0_enable=0.
REQ-034 SHALL test a conflict stream with ROUND_ROBIN=1: ALU x3=1 and MEM x4=2 held valid for 4 cycles -> grants MEM, ALU, MEM, ALU; with ROUND_ROBIN=0 -> MEM in all 4 cycles and alu_ready=0.
REQ-035 SHALL test the scoreboard: issue x7 -> pending_mask=0x00000080 and query0_busy=1 for index 7; MEM write of x7 -> the bit clears 1 cycle later; query stays busy during the write0 cycle and is 0 on the next cycle.
REQ-036 SHALL test simultaneous set and clear: pending x9, then issue x9 and MEM transfer x9 in the same cycle -> bit 9 stays 1.
REQ-037 SHALL test index 0: issue x0 and a MEM write to x0 -> pending_mask stays 0 and write0_enable stays 0; query of index 0 -> busy=0.
REQ-038 SHALL test reset mid-operation: pending_mask=0x00000F00 with a transfer in flight, then assert reset -> all outputs 0 on the next edge and no write0_enable pulse.
